// File: rtl/riscv_core_amo_pkg.sv
// riscv_core_amo_pkg: shared encodings for the AMO/LR/SC sequencer and its ALU.
package riscv_core_amo_pkg;
  typedef enum logic [3:0] {
    SWAP = 4'd0, ADD = 4'd1, XOR = 4'd2, AND = 4'd3, OR = 4'd4,
    MIN = 4'd5, MAX = 4'd6, MINU = 4'd7, MAXU = 4'd8
  } amo_op_e;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} amo_state_e;
  typedef enum logic [1:0] {K_AMO, K_LR, K_SC} amo_kind_e;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;
  localparam int GRANULE_LSB = 3;
endpackage

// File: rtl/riscv_core_amo_alu.sv
// riscv_core_amo_alu: combinational AMO new-value computation; word ops use bits [31:0] only.
module riscv_core_amo_alu
  import riscv_core_amo_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  amo_op_e          op_i,
  input  logic [1:0]       size_i,
  input  logic [XLEN-1:0]  old_i,
  input  logic [XLEN-1:0]  rs2_i,
  output logic [XLEN-1:0]  new_o
);
  logic word, lt_s, lt_u;
  logic [XLEN-1:0] sa, sb, ua, ub, r;
  always_comb begin
    word = size_i == SIZE_W;
    sa = word ? {{(XLEN-32){old_i[31]}}, old_i[31:0]} : old_i;
    sb = word ? {{(XLEN-32){rs2_i[31]}}, rs2_i[31:0]} : rs2_i;
    ua = word ? {{(XLEN-32){1'b0}}, old_i[31:0]} : old_i;
    ub = word ? {{(XLEN-32){1'b0}}, rs2_i[31:0]} : rs2_i;
    lt_s = $signed(sa) < $signed(sb);
    lt_u = ua < ub;
    case (op_i)
      SWAP:    r = rs2_i;
      ADD:     r = old_i + rs2_i;
      XOR:     r = old_i ^ rs2_i;
      AND:     r = old_i & rs2_i;
      OR:      r = old_i | rs2_i;
      MIN:     r = lt_s ? old_i : rs2_i;
      MAX:     r = lt_s ? rs2_i : old_i;
      MINU:    r = lt_u ? old_i : rs2_i;
      MAXU:    r = lt_u ? rs2_i : old_i;
      default: r = old_i;
    endcase
    new_o = word ? {{(XLEN-32){1'b0}}, r[31:0]} : r;
  end
endmodule

// File: rtl/riscv_core_amo_sequencer.sv
// riscv_core_amo_sequencer: MEM-stage AMO/LR/SC read-modify-write sequencer with LR/SC reservation.
// Define RISCV_CORE_LRSC_TIMEOUT_EN to expire an idle reservation after RES_TIMEOUT cycles.
module riscv_core_amo_sequencer
  import riscv_core_amo_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int RES_TIMEOUT = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_amo,
  input  logic [3:0]       i_amo_op,
  input  logic             i_lr,
  input  logic             i_sc,
  input  logic [1:0]       i_size,
  input  logic [XLEN-1:0]  i_addr,
  input  logic [XLEN-1:0]  i_rs2,
  input  logic             i_flush,
  input  logic             i_snoop_valid,
  input  logic [XLEN-1:0]  i_snoop_addr,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [XLEN-1:0]  o_mem_addr,
  output logic [XLEN-1:0]  o_mem_wdata,
  output logic [1:0]       o_mem_size,
  input  logic             i_mem_ready,
  input  logic             i_mem_rvalid,
  input  logic [XLEN-1:0]  i_mem_rdata,
  output logic             o_stall,
  output logic             o_done,
  output logic [XLEN-1:0]  o_result,
  output logic             o_misaligned
);
  localparam int GW = XLEN - GRANULE_LSB;
  amo_state_e state_q, state_d;
  amo_kind_e kind_q, kind_d;
  amo_op_e op_q, op_d;
  logic [XLEN-1:0] addr_q, addr_d, rs2_q, rs2_d, result_q, result_d, rdata_x, alu_new;
  logic [1:0] size_q, size_d;
  logic misal_q, misal_d, res_valid_q, res_valid_d, start, misal, sc_ok;
  logic [GW-1:0] res_gran_q, res_gran_d;
`ifdef RISCV_CORE_LRSC_TIMEOUT_EN
  localparam int TW = $clog2(RES_TIMEOUT + 1);
  logic [TW-1:0] to_q, to_d;
`endif
  riscv_core_amo_alu #(.XLEN(XLEN)) u_alu (
    .op_i(op_q), .size_i(size_q), .old_i(result_q), .rs2_i(rs2_q), .new_o(alu_new)
  );
  always_comb begin
    start = i_amo | i_lr | i_sc;
    misal = i_size == SIZE_D ? |i_addr[2:0] : |i_addr[1:0];
    sc_ok = res_valid_q && res_gran_q == i_addr[XLEN-1:GRANULE_LSB];
    rdata_x = size_q == SIZE_W ? {{(XLEN-32){i_mem_rdata[31]}}, i_mem_rdata[31:0]} : i_mem_rdata;
    state_d = state_q;
    kind_d = kind_q;
    op_d = op_q;
    addr_d = addr_q;
    rs2_d = rs2_q;
    size_d = size_q;
    result_d = result_q;
    misal_d = misal_q;
    res_valid_d = res_valid_q;
    res_gran_d = res_gran_q;
`ifdef RISCV_CORE_LRSC_TIMEOUT_EN
    to_d = (res_valid_q && to_q != '0) ? to_q - 1'b1 : to_q;
    if (res_valid_q && to_q == '0) res_valid_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (start && !i_flush) begin
        addr_d = i_addr;
        rs2_d = i_rs2;
        op_d = amo_op_e'(i_amo_op);
        size_d = i_size;
        kind_d = i_amo ? K_AMO : i_lr ? K_LR : K_SC;
        misal_d = misal;
        result_d = '0;
        if (misal) state_d = DONE;
        else if (i_amo | i_lr) state_d = RD_REQ;
        else begin
          state_d = sc_ok ? WR_REQ : DONE;
          result_d = {{(XLEN-1){1'b0}}, !sc_ok};
          res_valid_d = 1'b0;
        end
      end
      RD_REQ: state_d = i_flush ? IDLE : i_mem_ready ? RD_WAIT : RD_REQ;
      RD_WAIT: if (i_mem_rvalid) begin
        result_d = rdata_x;
        state_d = kind_q == K_LR ? DONE : WR_REQ;
        if (kind_q == K_LR) begin
          res_valid_d = 1'b1;
          res_gran_d = addr_q[XLEN-1:GRANULE_LSB];
`ifdef RISCV_CORE_LRSC_TIMEOUT_EN
          to_d = TW'(RES_TIMEOUT);
`endif
        end
      end
      WR_REQ: if (i_mem_ready) begin
        state_d = DONE;
        if (kind_q == K_AMO && res_gran_q == addr_q[XLEN-1:GRANULE_LSB]) res_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // comparing against the next granule also blocks an LR set hit by a same-cycle snoop
    if (i_snoop_valid && i_snoop_addr[XLEN-1:GRANULE_LSB] == res_gran_d) res_valid_d = 1'b0;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      kind_q <= K_AMO;
      op_q <= SWAP;
      addr_q <= '0;
      rs2_q <= '0;
      size_q <= '0;
      result_q <= '0;
      misal_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_gran_q <= '0;
`ifdef RISCV_CORE_LRSC_TIMEOUT_EN
      to_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      kind_q <= kind_d;
      op_q <= op_d;
      addr_q <= addr_d;
      rs2_q <= rs2_d;
      size_q <= size_d;
      result_q <= result_d;
      misal_q <= misal_d;
      res_valid_q <= res_valid_d;
      res_gran_q <= res_gran_d;
`ifdef RISCV_CORE_LRSC_TIMEOUT_EN
      to_q <= to_d;
`endif
    end
  end
  assign o_mem_req = state_q == RD_REQ || state_q == WR_REQ;
  assign o_mem_we = state_q == WR_REQ;
  assign o_mem_addr = addr_q;
  assign o_mem_size = size_q;
  assign o_mem_wdata = state_q != WR_REQ ? '0 : kind_q == K_SC ? rs2_q : alu_new;
  assign o_stall = (state_q == IDLE && start && !i_flush) || state_q inside {RD_REQ, RD_WAIT, WR_REQ};
  assign o_done = state_q == DONE;
  assign o_result = o_done ? result_q : '0;
  assign o_misaligned = o_done && misal_q;
endmodule

// File: tb/tb_riscv_core_amo_sequencer.sv
// tb_riscv_core_amo_sequencer: directed and randomized checks against a behavioural memory/reservation model.
module tb_riscv_core_amo_sequencer;
  import riscv_core_amo_pkg::*;
  logic clk = 1'b0, rst;
  logic i_amo, i_lr, i_sc, i_flush, i_snoop_valid, i_mem_ready, i_mem_rvalid;
  logic [3:0] i_amo_op;
  logic [1:0] i_size;
  logic [63:0] i_addr, i_rs2, i_snoop_addr, i_mem_rdata;
  logic o_mem_req, o_mem_we, o_stall, o_done, o_misaligned;
  logic [63:0] o_mem_addr, o_mem_wdata, o_result;
  logic [1:0] o_mem_size;
  int total = 0, bad = 0;
  logic [63:0] mem [logic [63:0]];
  bit res_v;
  logic [63:0] res_g;

  riscv_core_amo_sequencer dut (
    .i_clk(clk), .i_rst(rst), .i_amo(i_amo), .i_amo_op(i_amo_op), .i_lr(i_lr), .i_sc(i_sc),
    .i_size(i_size), .i_addr(i_addr), .i_rs2(i_rs2), .i_flush(i_flush),
    .i_snoop_valid(i_snoop_valid), .i_snoop_addr(i_snoop_addr),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_size(o_mem_size), .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid),
    .i_mem_rdata(i_mem_rdata), .o_stall(o_stall), .o_done(o_done), .o_result(o_result),
    .o_misaligned(o_misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] w);
    return {{32{w[31]}}, w};
  endfunction

  function automatic logic [63:0] amo_ref(input logic [3:0] opc, input bit word, input logic [63:0] o, input logic [63:0] b);
    longint so, sb;
    longint unsigned uo, ub;
    logic [63:0] r;
    so = word ? longint'($signed(o[31:0])) : longint'(o);
    sb = word ? longint'($signed(b[31:0])) : longint'(b);
    uo = word ? {32'b0, o[31:0]} : o;
    ub = word ? {32'b0, b[31:0]} : b;
    case (opc)
      4'd0: r = b;
      4'd1: r = o + b;
      4'd2: r = o ^ b;
      4'd3: r = o & b;
      4'd4: r = o | b;
      4'd5: r = so <= sb ? o : b;
      4'd6: r = so >= sb ? o : b;
      4'd7: r = uo <= ub ? o : b;
      default: r = uo >= ub ? o : b;
    endcase
    return word ? {32'b0, r[31:0]} : r;
  endfunction

  // k: 0 AMO, 1 LR, 2 SC; dly: not-ready cycles before each memory handshake
  task automatic op(input int k, input logic [3:0] opc, input logic [1:0] sz, input logic [63:0] a, input logic [63:0] d, input int dly);
    logic [63:0] g, cur, old, nv, exp_res, wd, obs_res;
    bit word, mis, exp_wr, rv, obs_mis;
    int exp_cyc, got, nwr, nrd, wc;
    g = a >> 3;
    word = sz == 2'b10;
    mis = word ? a[1:0] != 2'b0 : a[2:0] != 3'b0;
    cur = mem.exists(g) ? mem[g] : 64'h0;
    old = word ? sx(a[2] ? cur[63:32] : cur[31:0]) : cur;
    exp_res = old;
    exp_wr = 0;
    nv = 0;
    exp_cyc = 1;
    if (!mis) begin
      if (k == 0) begin
        nv = amo_ref(opc, word, old, d);
        exp_wr = 1;
        exp_cyc = 4 + 2 * dly;
        if (res_v && res_g == g) res_v = 0;
      end else if (k == 1) begin
        exp_cyc = 3 + dly;
        res_v = 1;
        res_g = g;
      end else begin
        exp_wr = res_v && res_g == g;
        exp_res = exp_wr ? 64'd0 : 64'd1;
        nv = word ? {32'b0, d[31:0]} : d;
        exp_cyc = exp_wr ? 2 + dly : 1;
        res_v = 0;
      end
      if (exp_wr) mem[g] = word ? (a[2] ? {nv[31:0], cur[31:0]} : {cur[63:32], nv[31:0]}) : nv;
    end
    @(negedge clk);
    chk("idle_no_done", 64'(o_done), 0);
    i_amo = k == 0; i_lr = k == 1; i_sc = k == 2;
    i_amo_op = opc; i_size = sz; i_addr = a; i_rs2 = d;
    #1 chk("start_stall", 64'(o_stall), 1);
    got = -1; nwr = 0; nrd = 0; wc = dly; rv = 0; wd = 0; obs_res = 0; obs_mis = 0;
    for (int c = 1; c <= 30 && got < 0; c++) begin
      @(negedge clk);
      i_amo = 0; i_lr = 0; i_sc = 0; i_mem_ready = 0;
      i_mem_rvalid = rv;
      i_mem_rdata = rv ? (word ? {$urandom, (a[2] ? cur[63:32] : cur[31:0])} : cur) : {$urandom, $urandom};
      rv = 0;
      if (o_done) begin
        got = c;
        obs_res = o_result;
        obs_mis = o_misaligned;
      end else if (o_mem_req) begin
        if (wc > 0) wc--;
        else begin
          wc = dly;
          i_mem_ready = 1;
          chk("req_addr", o_mem_addr, a);
          if (o_mem_we) begin nwr++; wd = o_mem_wdata; end
          else begin nrd++; rv = 1; end
        end
      end
    end
    i_mem_rvalid = 0;
    chk("done_cycle", 64'(got), 64'(exp_cyc));
    chk("misaligned", 64'(obs_mis), 64'(mis));
    if (!mis) chk("result", obs_res, exp_res);
    chk("writes", 64'(nwr), 64'(exp_wr));
    chk("reads", 64'(nrd), 64'(!mis && k != 2));
    if (exp_wr) chk("wdata", word ? {32'b0, wd[31:0]} : wd, nv);
  endtask

  task automatic snoop(input logic [63:0] a);
    @(negedge clk);
    i_snoop_valid = 1; i_snoop_addr = a;
    @(negedge clk);
    i_snoop_valid = 0;
    if (res_v && (a >> 3) == res_g) res_v = 0;
  endtask

  initial begin
    logic [63:0] a, d;
    logic [1:0] sz;
    logic [3:0] opc;
    int k, dly;
    rst = 1; i_amo = 0; i_lr = 0; i_sc = 0; i_flush = 0; i_snoop_valid = 0;
    i_mem_ready = 0; i_mem_rvalid = 0; i_amo_op = 0; i_size = 0; i_addr = 0; i_rs2 = 0;
    i_snoop_addr = 0; i_mem_rdata = 0; res_v = 0; res_g = 0;
    #1;
    chk("rst_req", 64'(o_mem_req), 0);
    chk("rst_we", 64'(o_mem_we), 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_wdata", o_mem_wdata, 0);
    chk("rst_size", 64'(o_mem_size), 0);
    chk("rst_stall", 64'(o_stall), 0);
    chk("rst_done", 64'(o_done), 0);
    chk("rst_result", o_result, 0);
    chk("rst_mis", 64'(o_misaligned), 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    // directed scenarios
    mem[64'h1000 >> 3] = 64'd5;
    op(0, ADD, 2'b11, 64'h1000, 64'd3, 0);
    mem[64'h1100 >> 3] = 64'h12345678_FFFFFFFF;
    op(0, MIN, 2'b10, 64'h1100, 64'd1, 0);
    op(0, MINU, 2'b10, 64'h1100, 64'd1, 0);
    mem[64'h2000 >> 3] = 64'h0000_DEAD_BEEF_0001;
    op(1, 4'd0, 2'b11, 64'h2000, 64'd0, 0);
    op(2, 4'd0, 2'b11, 64'h2000, 64'd7, 0);
    op(2, 4'd0, 2'b11, 64'h2000, 64'd7, 0);
    op(1, 4'd0, 2'b11, 64'h2000, 64'd0, 0);
    snoop(64'h2004);
    op(2, 4'd0, 2'b11, 64'h2000, 64'd7, 0);
    op(0, SWAP, 2'b10, 64'h1002, 64'd5, 0);
    op(1, 4'd0, 2'b11, 64'h2000, 64'd0, 0);
    op(2, 4'd0, 2'b10, 64'h2001, 64'd9, 0);
    op(2, 4'd0, 2'b10, 64'h2004, 64'd9, 1);
    // stalled read then flush; reservation must survive both flushes
    op(1, 4'd0, 2'b11, 64'h2000, 64'd0, 0);
    @(negedge clk);
    i_amo = 1; i_amo_op = 4'd0; i_size = 2'b11; i_addr = 64'h4000; i_rs2 = 64'd9;
    @(negedge clk);
    i_amo = 0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_req", 64'(o_mem_req), 1);
      chk("hold_we", 64'(o_mem_we), 0);
      chk("hold_addr", o_mem_addr, 64'h4000);
      chk("hold_size", 64'(o_mem_size), 64'(2'b11));
      chk("hold_stall", 64'(o_stall), 1);
      @(negedge clk);
    end
    i_flush = 1;
    @(negedge clk);
    i_flush = 0;
    chk("flush_done", 64'(o_done), 0);
    chk("flush_req", 64'(o_mem_req), 0);
    chk("flush_stall", 64'(o_stall), 0);
    i_sc = 1; i_flush = 1; i_addr = 64'h2000; i_size = 2'b11;
    #1 chk("flush_idle_stall", 64'(o_stall), 0);
    @(negedge clk);
    i_sc = 0; i_flush = 0;
    chk("flush_idle_done", 64'(o_done), 0);
    chk("flush_idle_req", 64'(o_mem_req), 0);
    op(2, 4'd0, 2'b11, 64'h2000, 64'h1234, 0);
    // randomized mix over three neighbouring granules
    for (int i = 0; i < 80; i++) begin
      a = 64'h3000 + 64'(8 * $urandom_range(0, 2)) + ($urandom_range(0, 1) != 0 ? 64'd4 : 64'd0);
      if ($urandom_range(0, 9) == 0) a = a + 64'($urandom_range(1, 3));
      sz = $urandom_range(0, 1) != 0 ? 2'b11 : 2'b10;
      k = int'($urandom_range(0, 2));
      opc = 4'($urandom_range(0, 8));
      d = {$urandom, $urandom};
      dly = int'($urandom_range(0, 2));
      if ($urandom_range(0, 5) == 0) snoop(64'h3000 + 64'(8 * $urandom_range(0, 2)) + 64'($urandom_range(0, 7)));
      op(k, opc, sz, a, d, dly);
    end
    // asynchronous reset while a read is outstanding
    op(1, 4'd0, 2'b11, 64'h2000, 64'd0, 0);
    @(negedge clk);
    i_amo = 1; i_amo_op = ADD; i_size = 2'b11; i_addr = 64'h1000; i_rs2 = 64'd1;
    @(negedge clk);
    i_amo = 0;
    chk("mid_req", 64'(o_mem_req), 1);
    i_mem_ready = 1;
    @(negedge clk);
    i_mem_ready = 0;
    rst = 1;
    #1;
    chk("mid_rst_req", 64'(o_mem_req), 0);
    chk("mid_rst_stall", 64'(o_stall), 0);
    chk("mid_rst_done", 64'(o_done), 0);
    res_v = 0;
    @(negedge clk);
    rst = 0; i_mem_rvalid = 1; i_mem_rdata = 64'd77;
    @(negedge clk);
    i_mem_rvalid = 0;
    chk("stale_rvalid_done", 64'(o_done), 0);
    chk("stale_rvalid_req", 64'(o_mem_req), 0);
    op(2, 4'd0, 2'b11, 64'h2000, 64'd5, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
